// File: rtl/vx_launch_pkg.sv
// Shared types and constants for the DCR launcher: FSM states, DCR addresses and
// the write table that maps a write index to its address/data pair.
package vx_launch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StGap,
        StHold,
        StWaitRise,
        StWaitFall,
        StDone
    } launch_state_e;

    localparam logic [11:0] DCR_STARTUP_ADDR0 = 12'h001;
    localparam logic [11:0] DCR_STARTUP_ADDR1 = 12'h002;
    localparam logic [11:0] DCR_ARG0          = 12'h003;
    localparam logic [11:0] DCR_ARG1          = 12'h004;
    localparam logic [11:0] DCR_MPM_CLASS     = 12'h005;

    localparam int unsigned NUM_DCR_WRITES = 5;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } dcr_entry_t;

    function automatic dcr_entry_t dcr_table(input logic [2:0]  idx,
                                             input logic [63:0] startup,
                                             input logic [63:0] arg,
                                             input logic [31:0] mpm);
        dcr_entry_t e;
        e.addr = DCR_MPM_CLASS;
        e.data = mpm;
        case (idx)
            3'd0: begin e.addr = DCR_STARTUP_ADDR0; e.data = startup[31:0]; end
            3'd1: begin e.addr = DCR_STARTUP_ADDR1; e.data = startup[63:32]; end
            3'd2: begin e.addr = DCR_ARG0;          e.data = arg[31:0];     end
            3'd3: begin e.addr = DCR_ARG1;          e.data = arg[63:32];    end
            default: ;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/vx_sat_counter.sv
// Up-counter with synchronous clear (priority over enable) that sticks at all-ones.
module vx_sat_counter #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vx_dcr_launcher.sv
// Programs the five kernel DCRs, holds the core in reset for RESET_HOLD cycles,
// releases it and measures the busy window with a timeout guard.
module vx_dcr_launcher
    import vx_launch_pkg::*;
#(
    parameter int unsigned DCR_ADDR_WIDTH = 12,
    parameter int unsigned DCR_DATA_WIDTH = 32,
    parameter int unsigned RESET_HOLD     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 12216,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [63:0]               startup_addr,
    input  logic [63:0]               kernel_arg,
    input  logic [31:0]               mpm_class,
    output logic                      dcr_wr_valid,
    output logic [DCR_ADDR_WIDTH-1:0] dcr_wr_addr,
    output logic [DCR_DATA_WIDTH-1:0] dcr_wr_data,
    output logic                      core_reset,
    input  logic                      gpu_busy,
    output logic                      active,
    output logic                      done,
    output logic                      timed_out,
    output logic [CNT_WIDTH-1:0]      run_cycles
);

    launch_state_e state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [63:0]   startup_q, startup_d;
    logic [63:0]   arg_q, arg_d;
    logic [31:0]   mpm_q, mpm_d;

    logic                      dcr_wr_valid_q, dcr_wr_valid_d;
    logic [DCR_ADDR_WIDTH-1:0] dcr_wr_addr_q, dcr_wr_addr_d;
    logic [DCR_DATA_WIDTH-1:0] dcr_wr_data_q, dcr_wr_data_d;
    logic                      core_reset_q, core_reset_d;
    logic                      done_q, done_d;
    logic                      timed_out_q, timed_out_d;
    logic [CNT_WIDTH-1:0]      run_cycles_q, run_cycles_d;

    logic                 hold_clr, hold_en, run_clr, run_en;
    logic [CNT_WIDTH-1:0] hold_cnt, run_cnt;
    logic                 timeout_hit;
    dcr_entry_t           entry;

    vx_sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (hold_clr),
        .enable(hold_en),
        .count (hold_cnt)
    );

    vx_sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_run_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (run_clr),
        .enable(run_en),
        .count (run_cnt)
    );

    assign timeout_hit = (run_cnt >= CNT_WIDTH'(TIMEOUT_CYCLES));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        startup_d    = startup_q;
        arg_d        = arg_q;
        mpm_d        = mpm_q;
        timed_out_d  = timed_out_q;
        run_cycles_d = run_cycles_q;
        hold_clr     = 1'b0;
        hold_en      = 1'b0;
        run_clr      = 1'b0;
        run_en       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    startup_d    = startup_addr;
                    arg_d        = kernel_arg;
                    mpm_d        = mpm_class;
                    timed_out_d  = 1'b0;
                    run_cycles_d = '0;
                    idx_d        = 3'd0;
                    state_d      = StWr;
                end
            end
            StWr: state_d = StGap;
            StGap: begin
                if (idx_q == 3'(NUM_DCR_WRITES - 1)) begin
                    hold_clr = 1'b1;
                    state_d  = StHold;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = StWr;
                end
            end
            StHold: begin
                hold_en = 1'b1;
                if (hold_cnt == CNT_WIDTH'(RESET_HOLD - 1)) begin
                    run_clr = 1'b1;
                    state_d = StWaitRise;
                end
            end
            StWaitRise: begin
                run_en = 1'b1;
                if (timeout_hit) begin
                    timed_out_d  = 1'b1;
                    run_cycles_d = CNT_WIDTH'(TIMEOUT_CYCLES);
                    state_d      = StDone;
                end else if (gpu_busy) begin
                    state_d = StWaitFall;
                end
            end
            StWaitFall: begin
                run_en = 1'b1;
                // Timeout takes priority over a busy fall in the same cycle.
                if (timeout_hit) begin
                    timed_out_d  = 1'b1;
                    run_cycles_d = CNT_WIDTH'(TIMEOUT_CYCLES);
                    state_d      = StDone;
                end else if (!gpu_busy) begin
                    run_cycles_d = run_cnt;
                    state_d      = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Output registers follow the next state so they line up with it.
        entry          = dcr_table(idx_d, startup_d, arg_d, mpm_d);
        dcr_wr_valid_d = (state_d == StWr);
        dcr_wr_addr_d  = dcr_wr_valid_d ? DCR_ADDR_WIDTH'(entry.addr) : dcr_wr_addr_q;
        dcr_wr_data_d  = dcr_wr_valid_d ? DCR_DATA_WIDTH'(entry.data) : dcr_wr_data_q;
        core_reset_d   = !(state_d inside {StWaitRise, StWaitFall});
        done_d         = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            idx_q          <= 3'd0;
            startup_q      <= '0;
            arg_q          <= '0;
            mpm_q          <= '0;
            dcr_wr_valid_q <= 1'b0;
            dcr_wr_addr_q  <= '0;
            dcr_wr_data_q  <= '0;
            core_reset_q   <= 1'b1;
            done_q         <= 1'b0;
            timed_out_q    <= 1'b0;
            run_cycles_q   <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            startup_q      <= startup_d;
            arg_q          <= arg_d;
            mpm_q          <= mpm_d;
            dcr_wr_valid_q <= dcr_wr_valid_d;
            dcr_wr_addr_q  <= dcr_wr_addr_d;
            dcr_wr_data_q  <= dcr_wr_data_d;
            core_reset_q   <= core_reset_d;
            done_q         <= done_d;
            timed_out_q    <= timed_out_d;
            run_cycles_q   <= run_cycles_d;
        end
    end

    assign dcr_wr_valid = dcr_wr_valid_q;
    assign dcr_wr_addr  = dcr_wr_addr_q;
    assign dcr_wr_data  = dcr_wr_data_q;
    assign core_reset   = core_reset_q;
    assign done         = done_q;
    assign timed_out    = timed_out_q;
    assign run_cycles   = run_cycles_q;
    assign active       = (state_q != StIdle);

endmodule

// File: tb/tb_vx_dcr_launcher.sv
// Bench for vx_dcr_launcher: instance A uses the default timeout, instance B a
// 50-cycle timeout; launches are observed per cycle and compared to a timing model.
module tb_vx_dcr_launcher;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 32;
    localparam int unsigned HOLD = 8;
    localparam int unsigned TO_A = 12216;
    localparam int unsigned TO_B = 50;
    localparam int MAXC = 400;
    localparam int EXP_REL = 2 * 5 + HOLD + 1;

    logic clk = 1'b0;
    logic reset;
    logic start_a, start_b, busy_a, busy_b;
    logic [63:0] sa, ka;
    logic [31:0] mc;
    logic valid_a, valid_b, core_a, core_b, active_a, active_b;
    logic done_a, done_b, to_a, to_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;
    logic [CW-1:0] run_a, run_b;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vx_dcr_launcher #(
        .DCR_ADDR_WIDTH(AW), .DCR_DATA_WIDTH(DW), .RESET_HOLD(HOLD),
        .TIMEOUT_CYCLES(TO_A), .CNT_WIDTH(CW)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .startup_addr(sa), .kernel_arg(ka),
        .mpm_class(mc), .dcr_wr_valid(valid_a), .dcr_wr_addr(addr_a), .dcr_wr_data(data_a),
        .core_reset(core_a), .gpu_busy(busy_a), .active(active_a), .done(done_a),
        .timed_out(to_a), .run_cycles(run_a)
    );

    vx_dcr_launcher #(
        .DCR_ADDR_WIDTH(AW), .DCR_DATA_WIDTH(DW), .RESET_HOLD(HOLD),
        .TIMEOUT_CYCLES(TO_B), .CNT_WIDTH(CW)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .startup_addr(sa), .kernel_arg(ka),
        .mpm_class(mc), .dcr_wr_valid(valid_b), .dcr_wr_addr(addr_b), .dcr_wr_data(data_b),
        .core_reset(core_b), .gpu_busy(busy_b), .active(active_b), .done(done_b),
        .timed_out(to_b), .run_cycles(run_b)
    );

    logic sel = 1'b0;
    logic s_valid, s_core, s_active, s_done, s_to;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    logic [CW-1:0] s_run;

    always_comb begin
        s_valid  = sel ? valid_b  : valid_a;
        s_core   = sel ? core_b   : core_a;
        s_active = sel ? active_b : active_a;
        s_done   = sel ? done_b   : done_a;
        s_to     = sel ? to_b     : to_a;
        s_addr   = sel ? addr_b   : addr_a;
        s_data   = sel ? data_b   : data_a;
        s_run    = sel ? run_b    : run_a;
    end

    // Per-launch observations, indexed by cycle since the start was accepted.
    logic ob_core [MAXC];
    logic ob_active [MAXC];
    int ob_n, ob_rel, ob_done_cnt, ob_done_cyc;
    int ob_pcyc[$];
    logic [AW-1:0] ob_paddr[$];
    logic [DW-1:0] ob_pdata[$];
    logic ob_to;
    logic [CW-1:0] ob_run, ob_run1;

    // Reference: busy high for release offsets [r, f); the measured window ends at f
    // unless the timeout t is reached first (or at the same offset).
    function automatic int model_run(input int r, input int f, input int t);
        if (r >= t || f >= t) return t;
        return f;
    endfunction

    function automatic logic model_to(input int r, input int f, input int t);
        return (r >= t || f >= t);
    endfunction

    task automatic do_launch(input logic s, input logic [63:0] a, input logic [63:0] k,
                             input logic [31:0] m, input int r, input int f,
                             input int extra_start);
        logic b;
        int off;
        sel = s; sa = a; ka = k; mc = m;
        ob_pcyc.delete(); ob_paddr.delete(); ob_pdata.delete();
        ob_rel = -1; ob_done_cnt = 0; ob_done_cyc = -1; ob_n = MAXC; ob_run1 = '1;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        for (int c = 1; c < MAXC; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            ob_core[c] = s_core;
            ob_active[c] = s_active;
            if (c == 1) ob_run1 = s_run;
            if (s_valid) begin
                ob_pcyc.push_back(c);
                ob_paddr.push_back(s_addr);
                ob_pdata.push_back(s_data);
            end
            if (!s_core && ob_rel < 0) ob_rel = c;
            if (s_done) begin
                ob_done_cnt++;
                if (ob_done_cyc < 0) ob_done_cyc = c;
            end
            off = (ob_rel >= 0) ? c - ob_rel : -1;
            b = (ob_rel >= 0) && (off >= r) && (off < f);
            if (s) busy_b = b; else busy_a = b;
            if (c == extra_start) begin
                if (s) start_b = 1'b1; else start_a = 1'b1;
            end
            if (ob_done_cyc >= 0 && c >= ob_done_cyc + 3) begin
                ob_n = c + 1;
                break;
            end
        end
        ob_to = s_to;
        ob_run = s_run;
        busy_a = 1'b0;
        busy_b = 1'b0;
    endtask

    task automatic test_reset();
        logic [AW+DW+CW+4:0] got, exp;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        exp = {1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0, {CW{1'b0}}};
        got = {valid_a, addr_a, data_a, core_a, active_a, done_a, to_a, run_a};
        n_tests++;
        if (got !== exp) begin
            n_fail++; $display("FAIL reset_a: got %0h want %0h", got, exp);
        end
        got = {valid_b, addr_b, data_b, core_b, active_b, done_b, to_b, run_b};
        n_tests++;
        if (got !== exp) begin
            n_fail++; $display("FAIL reset_b: got %0h want %0h", got, exp);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_launch();
        int ea[5] = '{1, 2, 3, 4, 5};
        logic [31:0] ed[5] = '{32'h7000, 32'h0, 32'h12000, 32'h0, 32'h0};
        int bad = 0;
        do_launch(1'b0, 64'h7000, 64'h12000, 32'h0, 3, 20, -1);
        n_tests++;
        if (ob_pcyc.size() !== 5) begin
            n_fail++; $display("FAIL basic_npulses: got %0d want 5", ob_pcyc.size());
        end
        for (int i = 0; i < 5 && i < ob_pcyc.size(); i++) begin
            n_tests++;
            if (ob_pcyc[i] !== 1 + 2 * i || ob_paddr[i] !== AW'(ea[i]) ||
                ob_pdata[i] !== ed[i]) begin
                n_fail++;
                $display("FAIL basic_write%0d: got cyc %0d %0h=%0h want cyc %0d %0h=%0h",
                         i, ob_pcyc[i], ob_paddr[i], ob_pdata[i], 1 + 2 * i, ea[i], ed[i]);
            end
        end
        for (int c = 1; c < EXP_REL; c++) if (ob_core[c] !== 1'b1) bad++;
        n_tests++;
        if (ob_rel !== EXP_REL || bad !== 0) begin
            n_fail++;
            $display("FAIL basic_release: got cyc %0d early_low %0d want cyc %0d", ob_rel, bad,
                     EXP_REL);
        end
        n_tests++;
        if (s_addr !== AW'(5) || s_data !== 32'h0) begin
            n_fail++; $display("FAIL basic_retain: got %0h=%0h want 5=0", s_addr, s_data);
        end
    endtask

    task automatic test_run_measurement();
        int bad = 0;
        do_launch(1'b0, 64'h7000, 64'h12000, 32'h3, 3, 100, -1);
        n_tests++;
        if (ob_done_cnt !== 1 || ob_done_cyc !== EXP_REL + 101) begin
            n_fail++;
            $display("FAIL run_done: got %0d pulses at %0d want 1 at %0d", ob_done_cnt,
                     ob_done_cyc, EXP_REL + 101);
        end
        n_tests++;
        if (ob_run !== 32'd100 || ob_to !== 1'b0) begin
            n_fail++; $display("FAIL run_value: got %0d to=%0b want 100 to=0", ob_run, ob_to);
        end
        n_tests++;
        if (ob_done_cyc > 0 && (ob_core[ob_done_cyc] !== 1'b1 || ob_core[ob_n - 1] !== 1'b1)) begin
            n_fail++; $display("FAIL run_repark: got core_reset %0b want 1", ob_core[ob_done_cyc]);
        end
        for (int c = 1; c < ob_n; c++) if (ob_active[c] !== (c <= ob_done_cyc)) bad++;
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL run_active: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_no_busy();
        do_launch(1'b1, 64'h1234, 64'h5678, 32'h1, 1000, 1001, -1);
        n_tests++;
        if (ob_to !== 1'b1 || ob_run !== CW'(TO_B) || ob_done_cnt !== 1 ||
            ob_done_cyc !== EXP_REL + int'(TO_B) + 1) begin
            n_fail++;
            $display("FAIL no_busy: got to=%0b run=%0d done=%0d@%0d want to=1 run=%0d done=1@%0d",
                     ob_to, ob_run, ob_done_cnt, ob_done_cyc, TO_B, EXP_REL + int'(TO_B) + 1);
        end
    endtask

    task automatic test_simultaneous();
        do_launch(1'b1, 64'h42, 64'h43, 32'h0, 5, 49, -1);
        n_tests++;
        if (ob_run1 !== '0 || ob_to !== 1'b0 || ob_run !== 32'd49) begin
            n_fail++;
            $display("FAIL edge_49: got run1=%0d to=%0b run=%0d want 0 0 49", ob_run1, ob_to,
                     ob_run);
        end
        do_launch(1'b1, 64'h42, 64'h43, 32'h0, 5, 50, -1);
        n_tests++;
        if (ob_to !== 1'b1 || ob_run !== CW'(TO_B)) begin
            n_fail++;
            $display("FAIL simult: got to=%0b run=%0d want to=1 run=%0d", ob_to, ob_run, TO_B);
        end
    endtask

    task automatic test_start_while_active();
        int bad = 0;
        do_launch(1'b0, 64'hAAAA_0001, 64'hBBBB_0002, 32'h9, 2, 10, 6);
        n_tests++;
        if (ob_pcyc.size() !== 5) begin
            n_fail++; $display("FAIL busy_start_npulses: got %0d want 5", ob_pcyc.size());
        end
        for (int i = 0; i < ob_pcyc.size(); i++) if (ob_pcyc[i] !== 1 + 2 * i) bad++;
        for (int c = 1; c < ob_n; c++) if (ob_active[c] !== (c <= ob_done_cyc)) bad++;
        n_tests++;
        if (bad !== 0 || ob_done_cnt !== 1 || ob_run !== 32'd10) begin
            n_fail++;
            $display("FAIL busy_start_seq: got bad=%0d done=%0d run=%0d want 0 1 10", bad,
                     ob_done_cnt, ob_run);
        end
    endtask

    task automatic test_reset_mid();
        logic [AW+DW+CW+4:0] got, exp;
        int waited = 0;
        sel = 1'b0; sa = 64'h5555; ka = 64'h6666; mc = 32'h7;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        while (core_a !== 1'b0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        busy_a = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp = {1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0, {CW{1'b0}}};
        got = {valid_a, addr_a, data_a, core_a, active_a, done_a, to_a, run_a};
        n_tests++;
        if (got !== exp || waited >= 100) begin
            n_fail++; $display("FAIL reset_mid: got %0h want %0h (wait %0d)", got, exp, waited);
        end
        reset = 1'b0;
        busy_a = 1'b0;
        @(negedge clk);
        do_launch(1'b0, 64'h5555, 64'h6666, 32'h7, 4, 30, -1);
        n_tests++;
        if (ob_pcyc.size() !== 5 || ob_run !== 32'd30 || ob_to !== 1'b0 || ob_done_cnt !== 1) begin
            n_fail++;
            $display("FAIL relaunch: got np=%0d run=%0d to=%0b done=%0d want 5 30 0 1",
                     ob_pcyc.size(), ob_run, ob_to, ob_done_cnt);
        end
    endtask

    task automatic test_split();
        do_launch(1'b0, 64'h1_8000_0000, 64'h0, 32'h0, 1, 5, -1);
        n_tests++;
        if (ob_pcyc.size() < 2 || ob_paddr[0] !== AW'(1) || ob_pdata[0] !== 32'h8000_0000 ||
            ob_paddr[1] !== AW'(2) || ob_pdata[1] !== 32'h1) begin
            n_fail++;
            $display("FAIL split: got %0h=%0h %0h=%0h want 1=80000000 2=1", ob_paddr[0],
                     ob_pdata[0], ob_paddr[1], ob_pdata[1]);
        end
    endtask

    task automatic test_random();
        logic [63:0] a, k;
        logic [31:0] m;
        logic [31:0] ed[5];
        logic s;
        int r, f, t, bad;
        for (int it = 0; it < 8; it++) begin
            s = it[0];
            a = {$urandom, $urandom};
            k = {$urandom, $urandom};
            m = $urandom;
            t = s ? int'(TO_B) : int'(TO_A);
            r = s ? int'($urandom_range(0, 60)) : int'($urandom_range(0, 20));
            f = r + (s ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 120)));
            ed = '{a[31:0], a[63:32], k[31:0], k[63:32], m};
            do_launch(s, a, k, m, r, f, -1);
            bad = (ob_pcyc.size() == 5) ? 0 : 1;
            for (int i = 0; i < ob_pcyc.size() && i < 5; i++)
                if (ob_paddr[i] !== AW'(i + 1) || ob_pdata[i] !== ed[i]) bad++;
            n_tests++;
            if (bad !== 0) begin
                n_fail++; $display("FAIL rand%0d_writes: got %0d bad writes want 0", it, bad);
            end
            n_tests++;
            if (ob_run !== CW'(model_run(r, f, t)) || ob_to !== model_to(r, f, t) ||
                ob_done_cyc !== EXP_REL + model_run(r, f, t) + 1) begin
                n_fail++;
                $display("FAIL rand%0d_run: r=%0d f=%0d got %0d to=%0b @%0d want %0d to=%0b @%0d",
                         it, r, f, ob_run, ob_to, ob_done_cyc, model_run(r, f, t),
                         model_to(r, f, t), EXP_REL + model_run(r, f, t) + 1);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0; busy_a = 1'b0; busy_b = 1'b0;
        sa = '0; ka = '0; mc = '0;
        @(negedge clk);
        test_reset();
        test_basic_launch();
        test_run_measurement();
        test_no_busy();
        test_simultaneous();
        test_start_while_active();
        test_reset_mid();
        test_split();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
